// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with flush/stall handling, optional
//            load-use hazard detection (ID_EX_HAZARD_DETECT_EN) and a
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic        Branch_i,
    input  logic        MemtoReg_i,
    input  logic        MemWrite_i,
    input  logic        ALUSrc_i,
    input  logic        RegWrite_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [31:0] RS1data_i,
    input  logic [31:0] RS2data_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc_i,
    input  logic [9:0]  funct_i,
    input  logic [4:0]  RS1addr_i,
    input  logic [4:0]  RS2addr_i,
    input  logic [4:0]  RDaddr_i,
    output logic        valid_o,
    output logic        Branch_o,
    output logic        MemtoReg_o,
    output logic        MemWrite_o,
    output logic        ALUSrc_o,
    output logic        RegWrite_o,
    output logic [1:0]  ALUOp_o,
    output logic [31:0] RS1data_o,
    output logic [31:0] RS2data_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o,
    output logic [9:0]  funct_o,
    output logic [4:0]  RS1addr_o,
    output logic [4:0]  RS2addr_o,
    output logic [4:0]  RDaddr_o,
    output logic        hazard_o,
    output logic [15:0] bubble_cnt_o
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        r_valid;
    logic        r_branch;
    logic        r_memtoreg;
    logic        r_memwrite;
    logic        r_alusrc;
    logic        r_regwrite;
    logic [1:0]  r_aluop;
    logic [31:0] r_rs1data;
    logic [31:0] r_rs2data;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [9:0]  r_funct;
    logic [4:0]  r_rs1addr;
    logic [4:0]  r_rs2addr;
    logic [4:0]  r_rdaddr;
    logic [15:0] r_bubble_cnt;

    logic        w_hazard;
    logic        w_bubble;
    logic        w_load;

`ifdef ID_EX_HAZARD_DETECT_EN
    // A load in EX whose destination is read by the instruction in ID.
    assign w_hazard = r_valid & r_memtoreg & r_regwrite & (r_rdaddr != 5'd0) & valid_i &
                      ((r_rdaddr == RS1addr_i) | (r_rdaddr == RS2addr_i));
`else
    assign w_hazard = 1'b0;
`endif

    // Flush wins over stall; stall wins over hazard.
    assign w_bubble = flush_i | (~stall_i & w_hazard);
    assign w_load   = ~flush_i & ~stall_i & ~w_hazard;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= 1'b0;
            r_branch   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_aluop    <= 2'b00;
            r_rdaddr   <= 5'd0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_branch   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_aluop    <= 2'b00;
            r_rdaddr   <= 5'd0;
        end else if (w_load) begin
            r_valid    <= valid_i;
            r_branch   <= Branch_i;
            r_memtoreg <= MemtoReg_i;
            r_memwrite <= MemWrite_i;
            r_alusrc   <= ALUSrc_i;
            r_regwrite <= RegWrite_i;
            r_aluop    <= ALUOp_i;
            r_rdaddr   <= RDaddr_i;
        end
    end

    // Operand/data fields keep their contents across a bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rs1data <= 32'd0;
            r_rs2data <= 32'd0;
            r_imm     <= 32'd0;
            r_pc      <= 32'd0;
            r_funct   <= 10'd0;
            r_rs1addr <= 5'd0;
            r_rs2addr <= 5'd0;
        end else if (w_load) begin
            r_rs1data <= RS1data_i;
            r_rs2data <= RS2data_i;
            r_imm     <= imm_i;
            r_pc      <= pc_i;
            r_funct   <= funct_i;
            r_rs1addr <= RS1addr_i;
            r_rs2addr <= RS2addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign valid_o      = r_valid;
    assign Branch_o     = r_branch;
    assign MemtoReg_o   = r_memtoreg;
    assign MemWrite_o   = r_memwrite;
    assign ALUSrc_o     = r_alusrc;
    assign RegWrite_o   = r_regwrite;
    assign ALUOp_o      = r_aluop;
    assign RS1data_o    = r_rs1data;
    assign RS2data_o    = r_rs2data;
    assign imm_o        = r_imm;
    assign pc_o         = r_pc;
    assign funct_o      = r_funct;
    assign RS1addr_o    = r_rs1addr;
    assign RS2addr_o    = r_rs2addr;
    assign RDaddr_o     = r_rdaddr;
    assign hazard_o     = w_hazard;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: stall_i  input  1  downstream freeze; hold all registered state.
REQ-004 SHALL: flush_i  input  1  branch-taken kill; load bubble.
REQ-005 SHALL: valid_i  input  1  decode-stage instruction valid.
REQ-006 SHALL: Branch_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i  input  1 each  control from decoder.
REQ-007 SHALL: ALUOp_i  input  2  ALU op class from decoder.
REQ-008 SHALL: RS1data_i, RS2data_i, imm_i, pc_i  input  32 each  operands, immediate, PC.
REQ-009 SHALL: funct_i  input  10  {funct7, funct3}.
REQ-010 SHALL: RS1addr_i, RS2addr_i, RDaddr_i  input  5 each  register indices.
REQ-011 SHALL: every input in REQ-005..REQ-010 has a registered output of same name with _o suffix and same width.
REQ-012 SHALL: hazard_o  output  1  load-use detected; IF/ID must hold this cycle.
REQ-013 SHALL: bubble_cnt_o  output  16  count of bubbles inserted.

Function
REQ-014 SHALL: per rising edge apply first matching case: flush_i, stall_i, hazard_o, else load.
REQ-015 SHALL: flush case -- all control outputs 0, valid_o 0, RDaddr_o 0, other data outputs hold; bubble_cnt_o increments.
REQ-016 SHALL: stall case -- every output register holds, bubble_cnt_o holds, no bubble inserted even if hazard_o is 1.
REQ-017 SHALL: hazard case -- same register effect as flush case (REQ-015); bubble_cnt_o increments.
REQ-018 SHALL: load case -- all _o registers take their _i values; latency exactly 1 cycle.
REQ-019 SHALL: hazard_o combinational = valid_o & MemtoReg_o & RegWrite_o & (RDaddr_o != 0) & valid_i & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i)).
REQ-020 SHALL: one load-use produces exactly one bubble; after it valid_o=0 so hazard_o deasserts and the held instruction loads next edge.
REQ-021 SHALL: bubble_cnt_o saturates at 16'hFFFF; no wrap.
REQ-022 SHALL: valid_i=0 in load case loads valid_o=0 and controls as presented; not counted as bubble.
REQ-023 SHALL: no combinational path from any input to any output except hazard_o.

Reset
REQ-024 SHALL: rst_n_i low asynchronously clears every output register, including bubble_cnt_o, to 0, regardless of clock.
REQ-025 SHALL: reset asserted mid-stall or mid-hazard discards held instruction; first edge after deassertion is a normal REQ-014 evaluation.

Configuration
REQ-026 SHALL: macro ID_EX_HAZARD_DETECT_EN defined -- hazard_o per REQ-019 and hazard case per REQ-017 active.
REQ-027 SHALL: macro undefined -- hazard_o tied 0, hazard case never taken, bubble_cnt_o counts flushes only; all other behaviour identical.

Verification
REQ-028 SHALL: reset low mid-run with all outputs nonzero -> all outputs 0 immediately, before next edge.
REQ-029 SHALL: load with RegWrite_i=1, ALUOp_i=2'b10, RDaddr_i=5, RS1data_i=32'h1234 -> next edge RegWrite_o=1, ALUOp_o=2'b10, RDaddr_o=5, RS1data_o=32'h1234, valid_o=1.
REQ-030 SHALL: (EN) registered load MemtoReg_o=1, RegWrite_o=1, RDaddr_o=7; present RS2addr_i=7, valid_i=1 -> hazard_o=1; next edge valid_o=0, controls 0, bubble_cnt_o=1; following edge instruction loads.
REQ-031 SHALL: same as REQ-030 with RDaddr_o=0 and RS1addr_i=0 -> hazard_o=0, no bubble.
REQ-032 SHALL: flush_i=1 and stall_i=1 together with valid_o=1 -> next edge valid_o=0, RDaddr_o=0, bubble_cnt_o+1; stall_i=1 alone for 3 edges -> all outputs unchanged.
REQ-033 SHALL: preload bubble_cnt_o to 16'hFFFE via 2^16-2 flushes, then 3 more flushes -> bubble_cnt_o=16'hFFFF.
